iob_axis2fifo_arbiter: RTL and testbench

//  Frame-granular round-robin arbiter that shares one FIFO write port between N_IN AXI-Stream sources.

---
 rtl/iob_axis2fifo_arbiter.sv | 159 +++++++++++++++
 tb/tb_iob_axis2fifo_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axis2fifo_arbiter.sv
// Frame-granular round-robin arbiter: N_IN AXI-Stream sources share one FIFO
// write port. A grant is held from the first beat of a frame to its tlast
// beat, and each completed frame reports its source, length and overflow.
`timescale 1ns/1ps
module iob_axis2fifo_arbiter #(
  parameter  int N_IN   = 2,
  parameter  int DATA_W = 32,
  parameter  int LEN_W  = 16,
  localparam int SRC_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                   clk_i,
  input  logic                   cke_i,
  input  logic                   arst_n_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [N_IN*DATA_W-1:0] axis_tdata_i,
  input  logic [N_IN-1:0]        axis_tvalid_i,
  input  logic [N_IN-1:0]        axis_tlast_i,
  output logic [N_IN-1:0]        axis_tready_o,
  input  logic                   fifo_full_i,
  output logic [DATA_W-1:0]      fifo_wdata_o,
  output logic                   fifo_write_o,
  output logic [N_IN-1:0]        grant_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [SRC_W-1:0]       frame_src_o,
  output logic [LEN_W-1:0]       frame_len_o,
  output logic                   frame_ovf_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_DONE} state_t;

  state_t            r_state;
  logic [N_IN-1:0]   r_grant;
  logic [SRC_W-1:0]  r_gidx;
  logic [SRC_W-1:0]  r_ptr;
  logic [LEN_W-1:0]  r_count;
  logic              r_ovf;
  logic [SRC_W-1:0]  r_src;
  logic [LEN_W-1:0]  r_len;
  logic              r_fovf;

  logic              w_sel_any;
  logic [SRC_W-1:0]  w_sel_idx;
  logic              w_ready;
  logic              w_valid;
  logic              w_last;
  logic              w_beat;
  logic [DATA_W-1:0] w_gdata;
  logic [LEN_W:0]    w_inc;

  // Saturating beat counter increment; MSB flags that a beat was lost to saturation.
  function automatic logic [LEN_W:0] sat_inc(input logic [LEN_W-1:0] c);
    if (&c) return {1'b1, c};
    else    return {1'b0, c + LEN_W'(1)};
  endfunction

  // Round-robin search: first valid source after the last-served pointer.
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    for (int i = 1; i <= N_IN; i++) begin
      if (!w_sel_any && axis_tvalid_i[(int'(r_ptr) + i) % N_IN]) begin
        w_sel_any = 1'b1;
        w_sel_idx = SRC_W'((int'(r_ptr) + i) % N_IN);
      end
    end
  end

  // AND-OR mux of the granted source's tdata (grant is one-hot).
  always_comb begin
    w_gdata = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (r_grant[k]) w_gdata = w_gdata | axis_tdata_i[k*DATA_W +: DATA_W];
    end
  end

  // tready is also gated by cke_i and rst_i so no beat is handshaked in a
  // cycle where the state cannot record it.
  assign w_ready       = (r_state == S_XFER) & en_i & ~fifo_full_i & cke_i & ~rst_i;
  assign w_valid       = |(axis_tvalid_i & r_grant);
  assign w_last        = |(axis_tlast_i & r_grant);
  assign w_beat        = w_ready & w_valid;
  assign w_inc         = sat_inc(r_count);

  assign axis_tready_o = r_grant & {N_IN{w_ready}};
  assign fifo_write_o  = w_beat;
  assign fifo_wdata_o  = w_beat ? w_gdata : '0;
  assign grant_o       = r_grant;
  assign busy_o        = (r_state == S_XFER) | (r_state == S_DONE);
  assign frame_done_o  = (r_state == S_DONE);
  assign frame_src_o   = r_src;
  assign frame_len_o   = r_len;
  assign frame_ovf_o   = r_fovf;

  // Arbiter FSM with registered grant, counter and frame report.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= SRC_W'(N_IN - 1);
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_src   <= '0;
      r_len   <= '0;
      r_fovf  <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        r_state <= S_IDLE;
        r_grant <= '0;
        r_gidx  <= '0;
        r_ptr   <= SRC_W'(N_IN - 1);
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_src   <= '0;
        r_len   <= '0;
        r_fovf  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (en_i) r_state <= S_ARB;
          end
          S_ARB: begin
            if (!en_i) begin
              r_state <= S_IDLE;
            end else if (w_sel_any) begin
              r_grant <= N_IN'(1) << w_sel_idx;
              r_gidx  <= w_sel_idx;
              r_state <= S_XFER;
            end
          end
          S_XFER: begin
            if (w_beat) begin
              r_count <= w_inc[LEN_W-1:0];
              r_ovf   <= r_ovf | w_inc[LEN_W];
              // Report is loaded with the tlast beat so it is valid during DONE.
              if (w_last) begin
                r_src   <= r_gidx;
                r_len   <= w_inc[LEN_W-1:0];
                r_fovf  <= r_ovf | w_inc[LEN_W];
                r_state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            r_ptr   <= r_gidx;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_grant <= '0;
            r_state <= en_i ? S_ARB : S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iob_axis2fifo_arbiter.sv
// Scoreboard bench for iob_axis2fifo_arbiter: directed frames from two
// sources, expected FIFO beats and frame reports queued in grant order.
`timescale 1ns/1ps
module tb_iob_axis2fifo_arbiter;
  localparam int N_IN   = 2;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 3;

  typedef struct {
    int src;
    int len;
    int ovf;
  } frm_t;

  logic                   clk = 1'b0;
  logic                   cke;
  logic                   arst_n;
  logic                   rst;
  logic                   en;
  logic [N_IN*DATA_W-1:0] axis_tdata;
  logic [N_IN-1:0]        axis_tvalid;
  logic [N_IN-1:0]        axis_tlast;
  logic [N_IN-1:0]        axis_tready;
  logic                   fifo_full;
  logic [DATA_W-1:0]      fifo_wdata;
  logic                   fifo_write;
  logic [N_IN-1:0]        grant;
  logic                   busy;
  logic                   frame_done;
  logic [0:0]             frame_src;
  logic [LEN_W-1:0]       frame_len;
  logic                   frame_ovf;

  logic                   s_valid [N_IN];
  logic                   s_last  [N_IN];
  logic [DATA_W-1:0]      s_data  [N_IN];

  logic [DATA_W-1:0]      q_data[$];
  frm_t                   q_frm[$];
  int                     n_checks = 0;
  int                     n_errors = 0;

  always #5 clk = ~clk;

  assign axis_tvalid = {s_valid[1], s_valid[0]};
  assign axis_tlast  = {s_last[1], s_last[0]};
  assign axis_tdata  = {s_data[1], s_data[0]};

  iob_axis2fifo_arbiter #(.N_IN(N_IN), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst), .en_i(en),
    .axis_tdata_i(axis_tdata), .axis_tvalid_i(axis_tvalid), .axis_tlast_i(axis_tlast),
    .axis_tready_o(axis_tready), .fifo_full_i(fifo_full), .fifo_wdata_o(fifo_wdata),
    .fifo_write_o(fifo_write), .grant_o(grant), .busy_o(busy), .frame_done_o(frame_done),
    .frame_src_o(frame_src), .frame_len_o(frame_len), .frame_ovf_o(frame_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event did not occur", name);
  endtask

  task automatic expect_frame(input int src, input int n, input logic [31:0] base,
                              input int len, input int ovf);
    frm_t f;
    for (int b = 0; b < n; b++) q_data.push_back(base + b);
    f.src = src; f.len = len; f.ovf = ovf;
    q_frm.push_back(f);
  endtask

  // Present one beat on a source and hold it until the handshake edge.
  task automatic drive_beat(input int src, input logic [31:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    s_valid[src] = 1'b1;
    s_data[src]  = d;
    s_last[src]  = last;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (axis_tready[src]) ok = 1'b1;
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int src, input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) drive_beat(src, base + b, (b == n - 1));
    s_valid[src] = 1'b0;
    s_last[src]  = 1'b0;
    s_data[src]  = '0;
  endtask

  task automatic wait_writes(input int n);
    int cnt;
    cnt = 0;
    for (int c = 0; c < 300 && cnt < n; c++) begin
      @(negedge clk);
      if (fifo_write) cnt++;
    end
    if (cnt < n) fail_now("write_timeout");
  endtask

  // Monitor: every FIFO write and frame report is checked against the queues.
  initial begin
    logic [DATA_W-1:0] e;
    frm_t f;
    forever begin
      @(negedge clk);
      if (arst_n) begin
        if (fifo_write) begin
          if (q_data.size() == 0) fail_now("unexpected_write");
          else begin
            e = q_data.pop_front();
            chk("fifo_wdata", fifo_wdata, e);
          end
        end else begin
          chk("wdata_idle_zero", fifo_wdata, 0);
        end
        if (frame_done) begin
          if (q_frm.size() == 0) fail_now("unexpected_frame_done");
          else begin
            f = q_frm.pop_front();
            chk("frame_src", frame_src, f.src);
            chk("frame_len", frame_len, f.len);
            chk("frame_ovf", frame_ovf, f.ovf);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cke = 1'b1; arst_n = 1'b0; rst = 1'b0; en = 1'b0; fifo_full = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      s_valid[k] = 1'b0; s_last[k] = 1'b0; s_data[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    #1 arst_n = 1'b1;
    @(negedge clk);
    chk("rst_len", frame_len, 0);
    chk("rst_src", frame_src, 0);
    chk("rst_ovf", frame_ovf, 0);
    chk("rst_tready", axis_tready, 0);
    chk("rst_write", fifo_write, 0);

    // 1: single 4-beat frame from source 0
    @(posedge clk); #1 en = 1'b1;
    expect_frame(0, 4, 32'h1000_0000, 4, 0);
    send_frame(0, 4, 32'h1000_0000);
    repeat (4) @(posedge clk); #1;

    // 2: both sources busy, alternating grants 0,1,0,1,0,1
    arst_n = 1'b0;
    @(posedge clk); #1 arst_n = 1'b1;
    expect_frame(0, 2, 32'h2000_0000, 2, 0);
    expect_frame(1, 3, 32'h2100_0000, 3, 0);
    expect_frame(0, 3, 32'h2000_0010, 3, 0);
    expect_frame(1, 1, 32'h2100_0010, 1, 0);
    expect_frame(0, 1, 32'h2000_0020, 1, 0);
    expect_frame(1, 2, 32'h2100_0020, 2, 0);
    fork
      begin
        send_frame(0, 2, 32'h2000_0000);
        send_frame(0, 3, 32'h2000_0010);
        send_frame(0, 1, 32'h2000_0020);
      end
      begin
        send_frame(1, 3, 32'h2100_0000);
        send_frame(1, 1, 32'h2100_0010);
        send_frame(1, 2, 32'h2100_0020);
      end
    join
    repeat (4) @(posedge clk); #1;

    // 3: FIFO full for 5 cycles mid-frame
    expect_frame(0, 6, 32'h3000_0000, 6, 0);
    fork
      send_frame(0, 6, 32'h3000_0000);
      begin
        wait_writes(3);
        @(posedge clk); #1 fifo_full = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("full_tready", axis_tready, 0);
          chk("full_write", fifo_write, 0);
          chk("full_grant", grant, 2'b01);
        end
        @(posedge clk); #1 fifo_full = 1'b0;
      end
    join
    repeat (4) @(posedge clk); #1;

    // 4: 10-beat frame saturates the 3-bit length counter
    expect_frame(1, 10, 32'h4000_0000, 7, 1);
    send_frame(1, 10, 32'h4000_0000);
    repeat (4) @(posedge clk); #1;

    // 5: soft reset mid-frame abandons the frame
    q_data.push_back(32'h5100_0000);
    q_data.push_back(32'h5100_0001);
    drive_beat(1, 32'h5100_0000, 1'b0);
    drive_beat(1, 32'h5100_0001, 1'b0);
    s_valid[1] = 1'b0; s_data[1] = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("sr_grant_held", grant, 2'b10);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("sr_grant_clear", grant, 0);
    chk("sr_busy_clear", busy, 0);
    expect_frame(0, 2, 32'h5000_0010, 2, 0);
    expect_frame(1, 2, 32'h5100_0010, 2, 0);
    fork
      send_frame(0, 2, 32'h5000_0010);
      send_frame(1, 2, 32'h5100_0010);
    join
    repeat (4) @(posedge clk); #1;

    // 6: en dropped mid-frame, then low through DONE into IDLE
    expect_frame(0, 4, 32'h6000_0000, 4, 0);
    fork
      send_frame(0, 4, 32'h6000_0000);
      begin
        bit seen;
        wait_writes(2);
        @(posedge clk); #1 en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("en_grant_held", grant, 2'b01);
          chk("en_tready", axis_tready, 0);
          chk("en_write", fifo_write, 0);
        end
        @(posedge clk); #1 en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
          @(negedge clk);
          if (frame_done) seen = 1'b1;
        end
        if (!seen) fail_now("done_timeout");
        chk("done_busy", busy, 1);
        en = 1'b0;
      end
    join
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
    expect_frame(1, 3, 32'h6100_0000, 3, 0);
    fork
      send_frame(1, 3, 32'h6100_0000);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("dis_grant", grant, 0);
          chk("dis_tready", axis_tready, 0);
        end
        @(posedge clk); #1 en = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("data_queue_empty", q_data.size(), 0);
    chk("frame_queue_empty", q_frm.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
